// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light sequencer: GREEN -> YELLOW -> ALL-RED rotation with a latched
// pedestrian WALK phase and a flashing-yellow maintenance mode, timed by a free-running prescaler.
module traffic_phase_ctrl #(
  parameter int NUM_DIRS = 3,
  parameter int TW       = 8,
  parameter int TICK_DIV = 3330000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ped_req,
  input  logic                flash_mode,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic                walk,
  output logic [2:0]          dir,
  output logic                tick
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          dir_q, dir_d, dir_nxt;
  logic [TW-1:0]       timer_q, timer_d, last;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic                ped_pend_q, ped_pend_d;
  logic                flash_ph_q, flash_ph_d;
  logic [NUM_DIRS-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d, onehot;
  logic                walk_q, walk_d;
  logic                expire;

  always_comb begin
    presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == PW'(TICK_DIV - 1));

    case (state_q)
      S_GREEN:  last = TW'(GREEN_T - 1);
      S_YELLOW: last = TW'(YELLOW_T - 1);
      S_WALK:   last = TW'(WALK_T - 1);
      default:  last = TW'(ALLRED_T - 1);
    endcase
    expire  = tick_q && (timer_q == last);
    dir_nxt = (dir_q == 3'(NUM_DIRS - 1)) ? 3'd0 : dir_q + 3'd1;

    state_d    = state_q;
    dir_d      = dir_q;
    flash_ph_d = tick_q ? ~flash_ph_q : flash_ph_q;
    ped_pend_d = ped_pend_q |
                 (ped_req && (state_q != S_WALK) && (state_q != S_FLASH));

    case (state_q)
      // A maintenance request ends GREEN early but always through YELLOW.
      S_GREEN:  if (flash_mode || expire) state_d = S_YELLOW;
      S_YELLOW: if (expire) state_d = S_ALLRED;
      S_ALLRED: begin
        if (expire) begin
          if (flash_mode) begin
            state_d = S_FLASH;
          end else if (ped_pend_q) begin
            state_d    = S_WALK;
            ped_pend_d = 1'b0;
          end else begin
            state_d = S_GREEN;
            dir_d   = dir_nxt;
          end
        end
      end
      S_WALK: begin
        if (expire) begin
          if (flash_mode) begin
            state_d = S_FLASH;
          end else begin
            state_d = S_GREEN;
            dir_d   = dir_nxt;
          end
        end
      end
      S_FLASH:  if (!flash_mode) state_d = S_ALLRED;
      default:  state_d = S_ALLRED;
    endcase

    if (state_d != state_q) timer_d = '0;
    else                    timer_d = tick_q ? timer_q + TW'(1) : timer_q;

    // Lamps are decoded from next state so they line up with the state register.
    onehot   = NUM_DIRS'(1) << dir_d;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    walk_d   = 1'b0;
    case (state_d)
      S_GREEN: begin
        green_d = onehot;
        red_d   = ~onehot;
      end
      S_YELLOW: begin
        yellow_d = onehot;
        red_d    = ~onehot;
      end
      S_WALK:  walk_d = 1'b1;
      S_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIRS{flash_ph_d}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_ALLRED;
      dir_q      <= 3'(NUM_DIRS - 1);
      timer_q    <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      ped_pend_q <= 1'b0;
      flash_ph_q <= 1'b0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      ped_pend_q <= ped_pend_d;
      flash_ph_q <= flash_ph_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      walk_q     <= walk_d;
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;
  assign walk   = walk_q;
  assign dir    = dir_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: the driver steps a countdown-based phase model and queues the expected
// lamps per cycle; a negedge monitor pops and compares, and also checks fixed timelines and lamp invariants.
module tb_traffic_phase_ctrl;
  localparam int N  = 3;
  localparam int TD = 4;
  localparam int GT = 3;
  localparam int YT = 1;
  localparam int AT = 1;
  localparam int WT = 2;

  localparam int P_GREEN  = 0;
  localparam int P_YELLOW = 1;
  localparam int P_ALLRED = 2;
  localparam int P_WALK   = 3;
  localparam int P_FLASH  = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ped_req = 1'b0;
  logic         flash_mode = 1'b0;
  logic [N-1:0] red, yellow, green;
  logic         walk, tick;
  logic [2:0]   dir;

  traffic_phase_ctrl #(
    .NUM_DIRS(N), .TW(8), .TICK_DIV(TD), .GREEN_T(GT),
    .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT)
  ) dut (
    .clock(clock), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .red(red), .yellow(yellow), .green(green), .walk(walk), .dir(dir), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] red;
    logic [N-1:0] yellow;
    logic [N-1:0] green;
    logic         walk;
    logic [2:0]   dir;
    logic         tick;
    int           seg;
    int           c;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase, approach, ticks left in phase, cycles since reset.
  int m_phase, m_dir, m_left, m_cyc;
  bit m_ped, m_ph, m_valid = 1'b0;

  function automatic int dur_of(input int ph);
    case (ph)
      P_GREEN:  return GT;
      P_YELLOW: return YT;
      P_WALK:   return WT;
      default:  return AT;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.red = '1; e.yellow = '0; e.green = '0;
    e.walk = (m_phase == P_WALK);
    e.dir  = 3'(m_dir);
    e.tick = ((m_cyc % TD) == TD - 1);
    e.seg  = 0;
    e.c    = m_cyc;
    for (int i = 0; i < N; i++) begin
      if (m_phase == P_FLASH) begin
        e.red[i]    = 1'b0;
        e.yellow[i] = m_ph;
      end else if (i == m_dir && m_phase == P_GREEN) begin
        e.red[i] = 1'b0; e.green[i] = 1'b1;
      end else if (i == m_dir && m_phase == P_YELLOW) begin
        e.red[i] = 1'b0; e.yellow[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input bit r, input bit p, input bit f);
    bit t, done, ped_new;
    int nxt;
    if (r) begin
      m_phase = P_ALLRED; m_dir = N - 1; m_left = AT; m_cyc = 0;
      m_ped = 1'b0; m_ph = 1'b0; m_valid = 1'b1;
      return;
    end
    t       = ((m_cyc % TD) == TD - 1);
    done    = t && (m_left == 1);
    ped_new = m_ped | (p && m_phase != P_WALK && m_phase != P_FLASH);
    nxt     = m_phase;
    case (m_phase)
      P_GREEN:  if (f || done) nxt = P_YELLOW;
      P_YELLOW: if (done) nxt = P_ALLRED;
      P_ALLRED: if (done) nxt = f ? P_FLASH : (m_ped ? P_WALK : P_GREEN);
      P_WALK:   if (done) nxt = f ? P_FLASH : P_GREEN;
      default:  if (!f) nxt = P_ALLRED;
    endcase
    if (nxt != m_phase) begin
      if (nxt == P_GREEN) m_dir = (m_dir + 1) % N;
      if (nxt == P_WALK) ped_new = 1'b0;
      m_left = dur_of(nxt);
    end else if (t) begin
      m_left = m_left - 1;
    end
    m_phase = nxt;
    m_ped   = ped_new;
    if (t) m_ph = !m_ph;
    m_cyc++;
  endtask

  // Called just after a posedge: queue this cycle's expectation, drive, advance the model.
  task automatic cyc(input bit r, input bit p, input bit f, input int seg);
    exp_t e;
    if (m_valid) begin
      e = model_out();
      e.seg = seg;
      expq.push_back(e);
    end
    reset = r; ped_req = p; flash_mode = f;
    model_step(r, p, f);
    @(posedge clock);
    #1;
  endtask

  logic [N-1:0] prev_green;
  bit           have_prev = 1'b0;

  always @(negedge clock) begin
    exp_t         e;
    logic [N-1:0] s_r, s_y, s_g;
    int           p, d;
    bit           b;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if ({red, yellow, green, walk, dir, tick} !== {e.red, e.yellow, e.green, e.walk, e.dir, e.tick}) begin
        n_bad++;
        $display("FAIL model seg=%0d c=%0d got r=%b y=%b g=%b w=%b d=%0d t=%b want r=%b y=%b g=%b w=%b d=%0d t=%b",
                 e.seg, e.c, red, yellow, green, walk, dir, tick,
                 e.red, e.yellow, e.green, e.walk, e.dir, e.tick);
      end

      if (e.seg == 1 && e.c < 100) begin
        s_r = '1; s_y = '0; s_g = '0;
        if (e.c >= 4) begin
          p = (e.c - 4) % 20;
          d = ((e.c - 4) / 20) % N;
          if (p < 12)      begin s_g[d] = 1'b1; s_r[d] = 1'b0; end
          else if (p < 16) begin s_y[d] = 1'b1; s_r[d] = 1'b0; end
        end
        n_cmp++;
        if ({red, yellow, green, walk} !== {s_r, s_y, s_g, 1'b0}) begin
          n_bad++;
          $display("FAIL idle_rotation c=%0d got r=%b y=%b g=%b w=%b want r=%b y=%b g=%b w=0",
                   e.c, red, yellow, green, walk, s_r, s_y, s_g);
        end
      end

      if (e.seg == 2 && e.c < 100) begin
        n_cmp++;
        if (walk !== (e.c >= 24 && e.c <= 31)) begin
          n_bad++;
          $display("FAIL ped_walk_window c=%0d got walk=%b want %b", e.c, walk, (e.c >= 24 && e.c <= 31));
        end
        if (e.c >= 32 && e.c <= 43) begin
          n_cmp++;
          if (green !== 3'b010) begin
            n_bad++;
            $display("FAIL green_after_walk c=%0d got %b want 010", e.c, green);
          end
        end
      end

      if (e.seg == 3) begin
        if (e.c >= 9 && e.c <= 11) begin
          n_cmp++;
          if ({red, yellow, green} !== {3'b110, 3'b001, 3'b000}) begin
            n_bad++;
            $display("FAIL flash_yellow_first c=%0d got r=%b y=%b g=%b want 110/001/000", e.c, red, yellow, green);
          end
        end
        if (e.c >= 16 && e.c <= 43) begin
          b = ((e.c / TD) % 2) == 1;
          n_cmp++;
          if ({red, yellow, green} !== {3'b000, {N{b}}, 3'b000}) begin
            n_bad++;
            $display("FAIL flash_blink c=%0d got r=%b y=%b g=%b want 000/%b/000", e.c, red, yellow, green, {N{b}});
          end
        end
        if (e.c >= 44 && e.c <= 47) begin
          n_cmp++;
          if ({red, green} !== {3'b111, 3'b000}) begin
            n_bad++;
            $display("FAIL flash_exit_allred c=%0d got r=%b g=%b want 111/000", e.c, red, green);
          end
        end
        if (e.c == 48) begin
          n_cmp++;
          if (green !== 3'b010) begin
            n_bad++;
            $display("FAIL flash_exit_green c=%0d got %b want 010", e.c, green);
          end
        end
      end

      n_cmp++;
      if ($countones(green) > 1) begin
        n_bad++;
        $display("FAIL two_greens c=%0d got %b want at most one set", e.c, green);
      end
      if (red != '0) begin
        for (int i = 0; i < N; i++) begin
          n_cmp++;
          if ($countones({red[i], yellow[i], green[i]}) != 1) begin
            n_bad++;
            $display("FAIL lamp_onehot c=%0d dir=%0d got rgy=%b%b%b want one lamp", e.c, i, red[i], green[i], yellow[i]);
          end
        end
      end
      if (have_prev && e.c > 0) begin
        n_cmp++;
        if ((prev_green & red) != '0) begin
          n_bad++;
          $display("FAIL green_to_red c=%0d prev_green=%b red=%b want no overlap", e.c, prev_green, red);
        end
      end
      prev_green = green;
      have_prev  = 1'b1;
    end
  end

  initial begin
    bit fl;
    cyc(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, 1);

    cyc(1'b1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 100; i++) cyc(1'b0, (i == 6), 1'b0, 2);

    cyc(1'b1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, (i >= 8 && i <= 42), 3);

    cyc(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 17; i++) cyc(1'b0, (i == 6), 1'b0, 5);
    cyc(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, 1);

    fl = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 249) == 0) fl = !fl;
      cyc(1'b0, ($urandom_range(0, 19) == 0), fl, 6);
    end

    repeat (3) @(posedge clock);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d entries want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
